// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_tx_arbiter                                            |
// | Description : Round-robin arbiter sharing one UART transmitter between   |
// |               NREQ byte requesters. Grants a client, strobes its byte    |
// |               into the transmitter, then counts baud ticks for the frame |
// |               (10 or 11 ticks) plus GAP_TICKS before re-arbitrating.     |
// | Ports       : clk, rst (sync, active-low)                                |
// |               req/req_data/req_last  - client requests, bytes, burst end |
// |               p_sel                  - parity enable (frame length)      |
// |               baud_tick_tx           - baud generator tick               |
// |               ack/grant_id           - accepted client                   |
// |               busy/tx_ready/tx_data  - transmitter handshake             |
// |               frame_done             - frame plus gap finished           |
// |               lock                   - burst lock (UART_ARB_BURST_EN)    |
// | Options     : `define UART_ARB_BURST_EN keeps the grant on one client    |
// |               until it sends a byte flagged with req_last.               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module uart_tx_arbiter #(
    parameter int NREQ      = 4,
    parameter int PTR_W     = 2,
    parameter int GAP_TICKS = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [8*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]     req_last,
    input  logic                p_sel,
    input  logic                baud_tick_tx,
    output logic [NREQ-1:0]     ack,
    output logic [PTR_W-1:0]    grant_id,
    output logic                busy,
    output logic                tx_ready,
    output logic [7:0]          tx_data,
    output logic                frame_done
`ifdef UART_ARB_BURST_EN
    ,
    output logic                lock
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SEND = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    localparam logic [PTR_W-1:0] c_last_idx = PTR_W'(NREQ - 1);
    localparam logic [NREQ-1:0]  c_one      = NREQ'(1);
    localparam logic [3:0]       c_gap_last = (GAP_TICKS == 0) ? 4'd0 : 4'(GAP_TICKS - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_cnt;
    logic [3:0]         w_cnt_nxt;
    logic [3:0]         r_fl;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_grant_id;
    logic [7:0]         r_tx_data;
    logic               w_any;
    logic [PTR_W-1:0]   w_sel;
    logic [PTR_W-1:0]   w_idx;
    logic               w_frame_done;

`ifdef UART_ARB_BURST_EN
    logic               r_lock;
`else
    logic               w_unused_last;
    assign w_unused_last = ^req_last;
`endif

    // Round-robin search: start one past the last grant and wrap at NREQ-1
    // (NREQ need not be a power of two, so the wrap is explicit).
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        w_idx = r_ptr;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (w_idx == c_last_idx) ? '0 : w_idx + PTR_W'(1);
            if (!w_any && req[w_idx]) begin
                w_any = 1'b1;
                w_sel = w_idx;
            end
        end
`ifdef UART_ARB_BURST_EN
        // While locked only the burst owner may be granted; others wait.
        if (r_lock) begin
            w_any = req[r_grant_id];
            w_sel = r_grant_id;
        end
`endif
    end

    // Next-state and frame timing. Ticks are counted only in SEND/GAP, so a
    // tick landing in the LOAD cycle is ignored.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_frame_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_SEND;
                w_cnt_nxt   = '0;
            end
            S_SEND: begin
                if (baud_tick_tx) begin
                    if (r_cnt == r_fl - 4'd1) begin
                        w_cnt_nxt = '0;
                        if (GAP_TICKS == 0) begin
                            w_state_nxt  = S_IDLE;
                            w_frame_done = 1'b1;
                        end else begin
                            w_state_nxt = S_GAP;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
            end
            S_GAP: begin
                if (baud_tick_tx) begin
                    if (r_cnt == c_gap_last) begin
                        w_cnt_nxt    = '0;
                        w_state_nxt  = S_IDLE;
                        w_frame_done = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_fl       <= 4'd10;
            r_ptr      <= c_last_idx;
            r_grant_id <= '0;
            r_tx_data  <= '0;
`ifdef UART_ARB_BURST_EN
            r_lock     <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (r_state == S_IDLE && w_any) begin
                r_tx_data  <= req_data[{w_sel, 3'b000} +: 8];
                r_grant_id <= w_sel;
                r_ptr      <= w_sel;
                // Frame length is latched here so later p_sel changes
                // cannot stretch or shorten the frame in flight.
                r_fl       <= p_sel ? 4'd11 : 4'd10;
`ifdef UART_ARB_BURST_EN
                r_lock     <= !req_last[w_sel];
`endif
            end
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign tx_ready   = (r_state == S_LOAD);
    assign ack        = tx_ready ? (c_one << r_grant_id) : '0;
    assign grant_id   = r_grant_id;
    assign tx_data    = r_tx_data;
    // A reset arriving on the final tick must not report a completed frame.
    assign frame_done = w_frame_done && rst;
`ifdef UART_ARB_BURST_EN
    assign lock       = r_lock;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_uart_tx_arbiter                                         |
// | Description : Self-checking bench for uart_tx_arbiter. A vector table     |
// |               drives requests; expected grants are queued and compared   |
// |               by a monitor when the arbiter strobes tx_ready/frame_done. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_uart_tx_arbiter;

    localparam int NREQ      = 4;
    localparam int PTR_W     = 2;
    localparam int GAP_TICKS = 1;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic        p_sel;
    logic        baud_tick_tx;
    logic [3:0]  ack;
    logic [1:0]  grant_id;
    logic        busy;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        frame_done;
`ifdef UART_ARB_BURST_EN
    logic        lock;
`endif

    uart_tx_arbiter #(
        .NREQ      (NREQ),
        .PTR_W     (PTR_W),
        .GAP_TICKS (GAP_TICKS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_data     (req_data),
        .req_last     (req_last),
        .p_sel        (p_sel),
        .baud_tick_tx (baud_tick_tx),
        .ack          (ack),
        .grant_id     (grant_id),
        .busy         (busy),
        .tx_ready     (tx_ready),
        .tx_data      (tx_data),
        .frame_done   (frame_done)
`ifdef UART_ARB_BURST_EN
        ,
        .lock         (lock)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] last;
        logic [7:0] data;
        logic       psel;
        logic       psel_mid;
        logic       load_tick;
        logic [3:0] req_after;
        int         exp_id;
        logic       exp_lock;
        int         pre_idle;
        int         abort_at;
    } vec_t;

    typedef struct {
        int         id;
        logic [7:0] data;
        int         len;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    sb_t  mon_it;
    int   n_checks = 0;
    int   n_errors = 0;
    int   done_cnt = 0;
    bit   mon_active = 0;
    bit   mon_after = 0;
    int   mon_ticks = 0;
    int   mon_len = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got event expected none/other", name);
    endtask

    // Scoreboard monitor: pops the expected grant on tx_ready, counts ticks
    // from the first SEND cycle and checks the frame length on frame_done.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                mon_active = 0;
                mon_after  = 0;
            end else begin
                if (mon_after) begin
                    chk("busy_after_done", 32'(busy), 32'(0));
                    mon_after = 0;
                end
                if (tx_ready) begin
                    if (mon_active) fail_now("grant_before_done");
                    if (sb.size() == 0) begin
                        fail_now("unexpected_grant");
                    end else begin
                        mon_it = sb.pop_front();
                        chk("ack", 32'(ack), 32'(4'b0001 << mon_it.id));
                        chk("grant_id", 32'(grant_id), 32'(mon_it.id));
                        chk("tx_data", 32'(tx_data), 32'(mon_it.data));
                        chk("busy_load", 32'(busy), 32'(1));
                        mon_len = mon_it.len;
                    end
                    mon_active = 1;
                    mon_ticks  = 0;
                end else if (mon_active && baud_tick_tx) begin
                    mon_ticks++;
                end
                if (frame_done) begin
                    if (!mon_active) begin
                        fail_now("spurious_frame_done");
                    end else begin
                        chk("frame_ticks", 32'(mon_ticks), 32'(mon_len));
                        mon_active = 0;
                        mon_after  = 1;
                    end
                    done_cnt++;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the first IDLE cycle.
    task automatic apply(input vec_t v);
        int  ticks;
        int  cyc;
        int  start;
        bit  seen;
        bit  aborted;
        repeat (v.pre_idle) begin
            @(posedge clk); #1;
        end
        req      = v.req;
        req_last = v.last;
        p_sel    = v.psel;
        for (int i = 0; i < 4; i++) req_data[8*i +: 8] = v.data + 8'(i);
        sb.push_back('{v.exp_id, v.data + 8'(v.exp_id), (v.psel ? 11 : 10) + GAP_TICKS});
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = tx_ready;
        end
        if (!seen) begin
            fail_now("ack_timeout");
            if (sb.size() > 0) sb.delete(0);
            req = '0;
            @(posedge clk); #1;
            return;
        end
`ifdef UART_ARB_BURST_EN
        chk("lock", 32'(lock), 32'(v.exp_lock));
`endif
        baud_tick_tx = v.load_tick;
        @(posedge clk); #1;
        baud_tick_tx = 1'b0;
        req          = v.req_after;
        ticks   = 0;
        cyc     = 0;
        aborted = 0;
        start   = done_cnt;
        while (done_cnt == start && cyc < 200 && !aborted) begin
            baud_tick_tx = ((cyc % 2) == 1);
            if (baud_tick_tx) begin
                ticks++;
                if (ticks >= 3) p_sel = v.psel_mid;
                if (v.abort_at > 0 && ticks == v.abort_at) begin
                    rst     = 1'b0;
                    aborted = 1;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        baud_tick_tx = 1'b0;
        if (aborted) begin
            rst = 1'b1;
            @(negedge clk);
            chk("busy_after_reset", 32'(busy), 32'(0));
            chk("done_after_reset", 32'(frame_done), 32'(0));
            @(posedge clk); #1;
        end else if (done_cnt == start) begin
            fail_now("frame_done_timeout");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; req = '0; req_data = '0; req_last = '0;
        p_sel = 1'b0; baud_tick_tx = 1'b0;

        // req, last, data, psel, psel_mid, load_tick, req_after, id, lock, pre, abort
        vecs.push_back('{4'b1111, 4'hF, 8'h10, 1'b0, 1'b0, 1'b0, 4'b1111, 0, 1'b0, 0, 0});
        vecs.push_back('{4'b1111, 4'hF, 8'h20, 1'b0, 1'b0, 1'b0, 4'b1111, 1, 1'b0, 0, 0});
        vecs.push_back('{4'b1111, 4'hF, 8'h30, 1'b0, 1'b0, 1'b0, 4'b1111, 2, 1'b0, 0, 0});
        vecs.push_back('{4'b1111, 4'hF, 8'h40, 1'b0, 1'b0, 1'b0, 4'b1111, 3, 1'b0, 0, 0});
        vecs.push_back('{4'b1111, 4'hF, 8'h50, 1'b0, 1'b0, 1'b0, 4'b0000, 0, 1'b0, 0, 0});
        vecs.push_back('{4'b0100, 4'hF, 8'hA3, 1'b0, 1'b0, 1'b0, 4'b0000, 2, 1'b0, 2, 0});
        vecs.push_back('{4'b0001, 4'hF, 8'h3C, 1'b1, 1'b0, 1'b0, 4'b0000, 0, 1'b0, 0, 0});
        vecs.push_back('{4'b0001, 4'hF, 8'h5A, 1'b0, 1'b0, 1'b0, 4'b0000, 0, 1'b0, 1, 0});
        vecs.push_back('{4'b1000, 4'hF, 8'h77, 1'b0, 1'b0, 1'b1, 4'b0000, 3, 1'b0, 0, 0});
        vecs.push_back('{4'b0011, 4'hF, 8'h81, 1'b0, 1'b0, 1'b0, 4'b0011, 0, 1'b0, 0, 0});
        vecs.push_back('{4'b0011, 4'hF, 8'h92, 1'b0, 1'b0, 1'b0, 4'b0000, 1, 1'b0, 0, 0});
        vecs.push_back('{4'b0110, 4'hF, 8'hB4, 1'b1, 1'b1, 1'b0, 4'b0000, 2, 1'b0, 0, 0});
        // Reset at the fifth SEND tick, then the pointer must restart at 0.
        vecs.push_back('{4'b0100, 4'hF, 8'hC3, 1'b0, 1'b0, 1'b0, 4'b0000, 2, 1'b0, 0, 5});
        vecs.push_back('{4'b1010, 4'hF, 8'hD0, 1'b0, 1'b0, 1'b0, 4'b0000, 1, 1'b0, 0, 0});
`ifdef UART_ARB_BURST_EN
        vecs.push_back('{4'b0011, 4'h0, 8'hE0, 1'b0, 1'b0, 1'b0, 4'b0010, 0, 1'b1, 0, 0});
        vecs.push_back('{4'b0011, 4'h0, 8'hE8, 1'b0, 1'b0, 1'b0, 4'b0010, 0, 1'b1, 5, 0});
        vecs.push_back('{4'b0011, 4'h1, 8'hF0, 1'b0, 1'b0, 1'b0, 4'b0010, 0, 1'b0, 3, 0});
        vecs.push_back('{4'b0010, 4'hF, 8'hF8, 1'b0, 1'b0, 1'b0, 4'b0000, 1, 1'b0, 0, 0});
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", 32'(ack), 32'(0));
        chk("rst_tx_ready", 32'(tx_ready), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_frame_done", 32'(frame_done), 32'(0));
        chk("rst_tx_data", 32'(tx_data), 32'(0));
        chk("rst_grant_id", 32'(grant_id), 32'(0));
`ifdef UART_ARB_BURST_EN
        chk("rst_lock", 32'(lock), 32'(0));
`endif
        @(posedge clk); #1;
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        repeat (4) @(posedge clk);
        chk("sb_empty", 32'(sb.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
